uart_hamming64_encoder: RTL and testbench

- Receives bytes over a UART line and frames them into 64-bit words under a simple command protocol.
- The protocol uses 8×0xAA to activate and 8×0x55 to idle.
- Each received 64-bit word is encoded into a 72-bit extended Hamming SECDED codeword.
- Sits between the board UART RX pin and the downstream transmit/storage logic.

---
 rtl/uart_hamming64_encoder_pkg.sv | 42 ++++
 rtl/uart_hamming64_encoder_rx.sv | 89 ++++++++
 rtl/uart_hamming64_encoder.sv | 121 ++++++++++++
 tb/tb_uart_hamming64_encoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hamming64_encoder_pkg.sv
// Shared constants, state types and the Hamming position map for the UART framed SECDED encoder.
package uart_hamming64_encoder_pkg;

    localparam int unsigned CLK_HZ_DEFAULT   = 50_000_000;
    localparam int unsigned BIT_RATE_DEFAULT = 9600;

    localparam logic [7:0]  ACTIVATE_BYTE = 8'hAA;
    localparam logic [7:0]  IDLE_BYTE     = 8'h55;
    localparam int unsigned CMD_REPEAT    = 8;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CODE_W = 72;
    localparam int unsigned PAR_W  = 7;

    typedef enum logic [1:0] {
        RX_WAIT_START,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        FR_IDLE,
        FR_ACTIVE
    } frame_state_t;

    // Codeword position of data bit idx: the idx-th position >= 3 that is not a power of two.
    function automatic logic [6:0] data_pos(input logic [5:0] idx);
        int unsigned seen;
        logic [6:0]  r;
        seen = 0;
        r    = '0;
        for (int unsigned p = 3; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == 32'(idx)) r = p[6:0];
                seen++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_hamming64_encoder_rx.sv
// UART 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, framing errors discarded.
module uart_rx_byte
    import uart_hamming64_encoder_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLK_HZ_DEFAULT / BIT_RATE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync;
    logic             rx_s;
    rx_state_t        state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             cnt_clr, shift_en, emit;

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else     sync <= {sync[0], rx_pin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_WAIT_START;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        emit       = 1'b0;
        unique case (state)
            RX_WAIT_START: begin
                cnt_clr = 1'b1;
                if (!rx_s) next_state = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    next_state = rx_s ? RX_WAIT_START : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) next_state = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr    = 1'b1;
                    emit       = rx_s;
                    next_state = RX_WAIT_START;
                end
            end
            default: next_state = RX_WAIT_START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            cnt      <= cnt_clr ? '0 : cnt + 1'b1;
            rx_valid <= emit;
            if (state != RX_DATA) bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift   <= {rx_s, shift[7:1]};
            if (emit)     rx_byte <= shift;
        end
    end

endmodule

// File: rtl/uart_hamming64_encoder.sv
// Frames UART bytes into 64-bit words (AA x8 activates, 55 x8 idles) and SECDED-encodes each word.
module uart_hamming64_encoder
    import uart_hamming64_encoder_pkg::*;
#(
    parameter int unsigned CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int unsigned BIT_RATE = BIT_RATE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx_pin,
    output logic [DATA_W-1:0] dataInput,
    output logic              dataIn64Done,
    output logic [CODE_W-1:0] codeWord,
    output logic              codeValid
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BIT_RATE;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    frame_state_t      state, next_state;
    logic [2:0]        aa_cnt;
    logic [2:0]        idx;
    logic [DATA_W-1:0] buffer, word_next;
    logic              last_byte, is_idle_word, word_done;
    logic [CODE_W-1:0] code_data, code;
    logic [PAR_W-1:0]  par;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (reset),
        .rx_pin   (uart_rx_pin),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    always_comb begin
        word_next = buffer;
        word_next[{idx, 3'b000} +: 8] = rx_byte;
    end

    assign last_byte    = rx_valid && (idx == 3'(CMD_REPEAT - 1));
    assign is_idle_word = (word_next == {CMD_REPEAT{IDLE_BYTE}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FR_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        word_done  = 1'b0;
        unique case (state)
            FR_IDLE: begin
                if (rx_valid && rx_byte == ACTIVATE_BYTE && aa_cnt == 3'(CMD_REPEAT - 1))
                    next_state = FR_ACTIVE;
            end
            FR_ACTIVE: begin
                if (last_byte) begin
                    if (is_idle_word) next_state = FR_IDLE;
                    else              word_done  = 1'b1;
                end
            end
            default: next_state = FR_IDLE;
        endcase
    end

    // idx wraps 7->0 naturally, so the next word starts at byte 0 without extra logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aa_cnt       <= '0;
            idx          <= '0;
            buffer       <= '0;
            dataInput    <= '0;
            dataIn64Done <= 1'b0;
        end else begin
            dataIn64Done <= word_done;
            if (word_done) dataInput <= word_next;
            if (state == FR_IDLE) begin
                idx <= '0;
                if (rx_valid) begin
                    if (rx_byte == ACTIVATE_BYTE && aa_cnt != 3'(CMD_REPEAT - 1))
                        aa_cnt <= aa_cnt + 1'b1;
                    else
                        aa_cnt <= '0;
                end
            end else begin
                aa_cnt <= '0;
                if (rx_valid) begin
                    buffer <= word_next;
                    idx    <= idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        code_data = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
            code_data[data_pos(i[5:0])] = dataInput[i[5:0]];
        par = '0;
        for (int unsigned k = 0; k < PAR_W; k++)
            for (int unsigned p = 1; p < CODE_W; p++)
                if (((p >> k) & 1) == 1) par[k[2:0]] = par[k[2:0]] ^ code_data[p[6:0]];
        code = code_data;
        for (int unsigned k = 0; k < PAR_W; k++)
            code[7'(32'd1 << k)] = par[k[2:0]];
        code[0] = ^code[CODE_W-1:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            codeWord  <= '0;
            codeValid <= 1'b0;
        end else begin
            codeValid <= dataIn64Done;
            if (dataIn64Done) codeWord <= code;
        end
    end

endmodule

// File: tb/tb_uart_hamming64_encoder.sv
// Directed + random bench for uart_hamming64_encoder against a byte-level framing model and reference encoder.
module tb_uart_hamming64_encoder;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx_pin = 1'b1;
    logic [63:0] dataInput;
    logic        dataIn64Done;
    logic [71:0] codeWord;
    logic        codeValid;

    int n_asserts = 0;
    int n_fail = 0;

    bit          m_active;
    int          m_aa, m_idx, m_words, done_cnt;
    logic [63:0] m_buf;
    logic [63:0] exp_q[$];

    uart_hamming64_encoder #(.CLK_HZ(50_000_000), .BIT_RATE(3_125_000)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_pin  (uart_rx_pin),
        .dataInput    (dataInput),
        .dataIn64Done (dataIn64Done),
        .codeWord     (codeWord),
        .codeValid    (codeValid)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] ref_encode(input logic [63:0] d);
        logic [71:0] cw;
        int j;
        cw = '0;
        j = 0;
        for (int p = 1; p < 72; p++)
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[j];
                j++;
            end
        for (int k = 0; k < 7; k++) begin
            int pp;
            pp = 1 << k;
            for (int p = 1; p < 72; p++)
                if (p != pp && ((p >> k) & 1) == 1) cw[pp] = cw[pp] ^ cw[p];
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_aa = 0;
        m_idx = 0;
        m_buf = '0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_active) begin
            if (b == 8'hAA) begin
                m_aa++;
                if (m_aa == 8) begin
                    m_active = 1;
                    m_aa = 0;
                    m_idx = 0;
                end
            end else m_aa = 0;
        end else begin
            m_buf[8*m_idx +: 8] = b;
            m_idx++;
            if (m_idx == 8) begin
                m_idx = 0;
                if (m_buf == {8{8'h55}}) m_active = 0;
                else begin
                    exp_q.push_back(m_buf);
                    m_words++;
                end
            end
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        uart_rx_pin = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            wait_clks(CPB);
        end
        if (good_stop) model_byte(b);
        uart_rx_pin = good_stop;
        wait_clks(CPB);
        uart_rx_pin = 1'b1;
        wait_clks(2 * CPB);
    endtask

    task automatic send_rep(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b, 1'b1);
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic step_check(input string tag);
        chk({tag, "_queue_empty"}, 72'(exp_q.size()), 72'd0);
        chk({tag, "_done_count"}, 72'(done_cnt), 72'(m_words));
    endtask

    // Output monitor: every dataIn64Done must match the model, codeValid must follow one clock later.
    task automatic monitor();
        bit          cv_pend;
        logic [71:0] cv_exp;
        logic [63:0] w;
        cv_pend = 0;
        cv_exp = '0;
        forever begin
            @(negedge clk);
            if (reset) cv_pend = 0;
            else begin
                if (cv_pend || codeValid) begin
                    chk("code_valid_timing", 72'(codeValid), 72'(cv_pend));
                    if (cv_pend) chk("code_word", codeWord, cv_exp);
                end
                cv_pend = 0;
                if (dataIn64Done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) chk("unexpected_done", 72'(dataIn64Done), 72'd0);
                    else begin
                        w = exp_q.pop_front();
                        chk("data_input", 72'(dataInput), 72'(w));
                        cv_pend = 1;
                        cv_exp = ref_encode(w);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #480;
        chk("rst_data_input", 72'(dataInput), 72'd0);
        chk("rst_done", 72'(dataIn64Done), 72'd0);
        chk("rst_code_word", codeWord, 72'd0);
        chk("rst_code_valid", 72'(codeValid), 72'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clks(4);
    endtask

    initial begin
        logic [63:0] rw;
        m_words = 0;
        done_cnt = 0;
        fork
            monitor();
        join_none

        do_reset();

        // Activate and send the first directed word.
        send_rep(8'hAA, 8);
        send_word(64'hAAAA00AAAAFFAAAA);
        step_check("first_word");
        chk("first_word_value", 72'(dataInput), 72'h00AAAA00AAAAFFAAAA);

        // Idle command, then a group that must be ignored until reactivated.
        send_rep(8'h55, 8);
        send_word(64'h0807060504030201);
        step_check("after_idle");
        chk("code_hold", codeWord, ref_encode(64'hAAAA00AAAAFFAAAA));
        send_rep(8'hAA, 8);
        send_word(64'h1122334455667788);
        step_check("reactivated");

        send_rep(8'hFF, 8);
        step_check("all_ones");
        chk("all_ones_data", 72'(dataInput), 72'h00FFFFFFFFFFFFFFFF);
        chk("all_ones_code", codeWord, 72'hFFFFFFFFFFFFFFFFFF);
        send_word(64'h0000000000000001);
        step_check("single_bit");
        chk("single_bit_code", codeWord, 72'h00000000000000000F);

        send_rep(8'h00, 8);
        step_check("all_zero");
        chk("all_zero_code", codeWord, 72'd0);

        // Return to idle, then a broken activation run.
        send_rep(8'h55, 8);
        send_rep(8'hAA, 7);
        send_byte(8'h12, 1'b1);
        send_rep(8'hAA, 7);
        send_word(64'h0102030405060708);
        step_check("broken_activation");
        send_rep(8'hAA, 8);
        send_word(64'hDEADBEEF01234567);
        step_check("late_activation");

        for (int n = 0; n < 4; n++) begin
            rw = {$urandom, $urandom};
            send_word(rw);
        end
        step_check("random_words");

        // Framing error inside a word: the bad byte must not occupy a slot.
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h99, 1'b0);
        wait_clks(2 * CPB);
        send_byte(8'h34, 1'b1);
        send_byte(8'h35, 1'b1);
        send_byte(8'h36, 1'b1);
        send_byte(8'h37, 1'b1);
        send_byte(8'h38, 1'b1);
        step_check("framing_error");

        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        do_reset();
        send_word(64'h5A5A5A5A5A5A5A5A);
        step_check("post_reset_idle");
        send_rep(8'hAA, 8);
        send_word(64'h0F1E2D3C4B5A6978);
        step_check("post_reset_active");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL timeout: observed simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
